csa_operand_framer: RTL and testbench

Upstream stage of the carry save adder. Accepts a serial stream of WIDTH-bit words over a valid/ready handshake, groups consecutive words into (a, b, c) triples and presents each triple to the CSA held stable until the consumer accepts it. Short frames terminated by in_last are zero-filled so the adder always sees three defined operands.

---
 rtl/csa_operand_framer_if.sv | 27 ++
 rtl/csa_operand_framer.sv | 149 ++++++++++++++
 tb/tb_csa_operand_framer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_operand_framer_if.sv
// rtl/csa_operand_framer_if.sv - word stream in, (a, b, c) triple out, for the CSA operand framer.
interface csa_operand_framer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             trip_valid;
   logic             trip_ready;
   logic             trip_short;
   logic [CNT_W-1:0] trip_cnt;

   modport master (
      output in_data, in_valid, in_last, trip_ready,
      input  in_ready, a, b, c, trip_valid, trip_short, trip_cnt
   );

   modport slave (
      input  in_data, in_valid, in_last, trip_ready,
      output in_ready, a, b, c, trip_valid, trip_short, trip_cnt
   );
endinterface

// File: rtl/csa_operand_framer.sv
// rtl/csa_operand_framer.sv - groups a word stream into zero-filled (a, b, c) triples for the CSA.
// Optional CSA_FRAMER_OVERLAP_EN adds a one-word pending register so input continues while a triple is held.
module csa_operand_framer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   csa_operand_framer_if.slave bus
);
   typedef enum logic [1:0] {S_A, S_B, S_C, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic             short_q, short_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready, word_acc, trip_acc;
   logic             ld_en, ld_last;
   logic [WIDTH-1:0] ld_data;
`ifdef CSA_FRAMER_OVERLAP_EN
   logic [WIDTH-1:0] pend_data_q, pend_data_d;
   logic             pend_last_q, pend_last_d;
   logic             pend_vld_q, pend_vld_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         short_q <= 1'b0;
         cnt_q   <= '0;
`ifdef CSA_FRAMER_OVERLAP_EN
         pend_data_q <= '0;
         pend_last_q <= 1'b0;
         pend_vld_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         short_q <= short_d;
         cnt_q   <= cnt_d;
`ifdef CSA_FRAMER_OVERLAP_EN
         pend_data_q <= pend_data_d;
         pend_last_q <= pend_last_d;
         pend_vld_q  <= pend_vld_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      short_d = short_q;
      cnt_d   = cnt_q;
      ld_en   = 1'b0;
      ld_data = '0;
      ld_last = 1'b0;
`ifdef CSA_FRAMER_OVERLAP_EN
      pend_data_d = pend_data_q;
      pend_last_d = pend_last_q;
      pend_vld_d  = pend_vld_q;
      in_ready    = !rst && ((state_q != S_HOLD) || !pend_vld_q);
`else
      in_ready    = !rst && (state_q != S_HOLD);
`endif
      word_acc = bus.in_valid && in_ready;
      trip_acc = (state_q == S_HOLD) && bus.trip_ready;

      case (state_q)
         S_A: begin
            if (word_acc) begin
               ld_en   = 1'b1;
               ld_data = bus.in_data;
               ld_last = bus.in_last;
            end
         end
         S_B: begin
            if (word_acc) begin
               b_d = bus.in_data;
               if (bus.in_last) begin
                  c_d     = '0;
                  short_d = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_C;
               end
            end
         end
         S_C: begin
            if (word_acc) begin
               c_d     = bus.in_data;
               short_d = 1'b0;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (trip_acc) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_A;
`ifdef CSA_FRAMER_OVERLAP_EN
               // a buffered word takes priority; otherwise a same-cycle word starts the next triple
               if (pend_vld_q) begin
                  ld_en      = 1'b1;
                  ld_data    = pend_data_q;
                  ld_last    = pend_last_q;
                  pend_vld_d = 1'b0;
               end else if (word_acc) begin
                  ld_en   = 1'b1;
                  ld_data = bus.in_data;
                  ld_last = bus.in_last;
               end
            end else if (word_acc) begin
               pend_data_d = bus.in_data;
               pend_last_d = bus.in_last;
               pend_vld_d  = 1'b1;
`endif
            end
         end
         default: state_d = S_A;
      endcase

      // first word of a triple: a single-word frame goes straight to hold with b=c=0
      if (ld_en) begin
         a_d = ld_data;
         if (ld_last) begin
            b_d     = '0;
            c_d     = '0;
            short_d = 1'b1;
            state_d = S_HOLD;
         end else begin
            state_d = S_B;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.a          = a_q;
   assign bus.b          = b_q;
   assign bus.c          = c_q;
   assign bus.trip_valid = (state_q == S_HOLD);
   assign bus.trip_short = short_q;
   assign bus.trip_cnt   = cnt_q;
endmodule

// File: tb/tb_csa_operand_framer.sv
// tb/tb_csa_operand_framer.sv - bench for csa_operand_framer: stream model checked every cycle plus pinned literals.
module tb_csa_operand_framer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   logic rand_tr = 1'b0;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic       s;
   } trip_t;

   trip_t      tq[$];
   logic [3:0] part[$];
   logic [7:0] m_cnt = 8'd0;

   csa_operand_framer_if #(.WIDTH(4), .CNT_W(8)) bus ();
   csa_operand_framer #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit model_ready();
`ifdef CSA_FRAMER_OVERLAP_EN
      return !(tq.size() >= 2 || (tq.size() == 1 && part.size() >= 1));
`else
      return tq.size() == 0;
`endif
   endfunction

   // model: words accepted in order, grouped by threes or by in_last, zero-filled
   always @(negedge clk) begin
      bit    exp_ir, exp_tv;
      trip_t t;
      if (rst) begin
         tq.delete();
         part.delete();
         m_cnt = 8'd0;
         chk("rst_in_ready", int'(bus.in_ready), 0);
         chk("rst_trip_valid", int'(bus.trip_valid), 0);
         chk("rst_abc", int'({bus.a, bus.b, bus.c}), 0);
         chk("rst_cnt", int'(bus.trip_cnt), 0);
         chk("rst_short", int'(bus.trip_short), 0);
      end else begin
         exp_tv = tq.size() > 0;
         exp_ir = model_ready();
         chk("trip_valid", int'(bus.trip_valid), int'(exp_tv));
         chk("in_ready", int'(bus.in_ready), int'(exp_ir));
         chk("trip_cnt", int'(bus.trip_cnt), int'(m_cnt));
         if (exp_tv) begin
            chk("a", int'(bus.a), int'(tq[0].a));
            chk("b", int'(bus.b), int'(tq[0].b));
            chk("c", int'(bus.c), int'(tq[0].c));
            chk("trip_short", int'(bus.trip_short), int'(tq[0].s));
         end
         if (bus.in_valid && exp_ir) begin
            part.push_back(bus.in_data);
            if (bus.in_last || part.size() == 3) begin
               t.a = part[0];
               t.b = (part.size() > 1) ? part[1] : 4'd0;
               t.c = (part.size() > 2) ? part[2] : 4'd0;
               t.s = (part.size() < 3);
               tq.push_back(t);
               part.delete();
            end
         end
         if (exp_tv && bus.trip_ready) begin
            void'(tq.pop_front());
            m_cnt = m_cnt + 8'd1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_tr) bus.trip_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic l);
      bit ok;
      int n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = l;
      do begin
         ok = bus.in_ready;
         step();
         n++;
      end while (!ok && n < 100);
      if (!ok) chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic accept();
      bus.trip_ready = 1'b1;
      step();
      bus.trip_ready = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (bus.trip_valid && n < 100) begin
         step();
         n++;
      end
      chk("drain_timeout", int'(bus.trip_valid), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      logic [5:0] sum;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.trip_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();

      send(4'd2, 1'b0); send(4'd9, 1'b0); send(4'd5, 1'b0);
      chk("t1_valid", int'(bus.trip_valid), 1);
      chk("t1_a", int'(bus.a), 2);
      chk("t1_b", int'(bus.b), 9);
      chk("t1_c", int'(bus.c), 5);
      sum = 6'(bus.a) + 6'(bus.b) + 6'(bus.c);
      chk("t1_sum", int'(sum), 16);
      accept();
      chk("t1_cnt", int'(bus.trip_cnt), 1);
      chk("t1_fall", int'(bus.trip_valid), 0);

      send(4'd10, 1'b0); send(4'd15, 1'b0); send(4'd13, 1'b0);
      repeat (5) begin
         step();
`ifdef CSA_FRAMER_OVERLAP_EN
         chk("t2_in_ready", int'(bus.in_ready), 1);
`else
         chk("t2_in_ready", int'(bus.in_ready), 0);
`endif
         chk("t2_abc", int'({bus.a, bus.b, bus.c}), 12'hAFD);
      end
      accept();
      chk("t2_cnt", int'(bus.trip_cnt), 2);

      send(4'd12, 1'b0); send(4'd9, 1'b1);
      chk("t3_abc", int'({bus.a, bus.b, bus.c}), 12'hC90);
      chk("t3_short", int'(bus.trip_short), 1);
      accept();
      send(4'd15, 1'b0); send(4'd15, 1'b0); send(4'd14, 1'b0);
      chk("t3_full_short", int'(bus.trip_short), 0);
      accept();
      chk("t3_cnt", int'(bus.trip_cnt), 4);

      send(4'd2, 1'b0); send(4'd9, 1'b0);
      rst = 1'b1;
      step();
      chk("t4_valid", int'(bus.trip_valid), 0);
      chk("t4_abc", int'({bus.a, bus.b, bus.c}), 0);
      chk("t4_cnt", int'(bus.trip_cnt), 0);
      rst = 1'b0;
      step();
      send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0);
      chk("t4_fresh", int'({bus.a, bus.b, bus.c}), 12'h123);
      accept();

      rand_tr = 1'b1;
      repeat (300) begin
         send(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) step();
      end
      drain();

      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      repeat (256) send(4'($urandom_range(0, 15)), 1'b1);
      drain();
      chk("wrap_cnt", int'(bus.trip_cnt), 0);

`ifdef CSA_FRAMER_OVERLAP_EN
      rand_tr = 1'b0;
      bus.trip_ready = 1'b1;
      send(4'd2, 1'b0); send(4'd9, 1'b0); send(4'd5, 1'b0);
      send(4'd10, 1'b0); send(4'd15, 1'b0); send(4'd13, 1'b0);
      step();
      chk("ov_cnt", int'(bus.trip_cnt), 2);
      bus.trip_ready = 1'b0;
`endif

      rand_tr = 1'b0;
      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
